// File: rtl/systolic_pkg.sv
// Shared types for the systolic array arbiter: FSM state encoding and
// index-width helper used by the top and the round-robin selector.
package systolic_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        CLR   = 3'd4
    } state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_arbiter_if.sv
// Handshake bundle between requesters, the arbiter and the shared systolic array.
// The arbiter uses the master modport; the environment uses slave.
interface systolic_arbiter_if #(
    parameter int NREQ = 2,
    parameter int BW   = 32
);
    logic [NREQ-1:0]         job_req;
    logic [NREQ-1:0]         job_gnt;
    logic [NREQ-1:0]         x_recv_val;
    logic [NREQ-1:0]         x_recv_rdy;
    logic [NREQ-1:0][BW-1:0] x_recv_msg;
    logic [NREQ-1:0]         w_recv_val;
    logic [NREQ-1:0]         w_recv_rdy;
    logic [NREQ-1:0][BW-1:0] w_recv_msg;
    logic                    arr_x_val;
    logic                    arr_x_rdy;
    logic [BW-1:0]           arr_x_msg;
    logic                    arr_w_val;
    logic                    arr_w_rdy;
    logic [BW-1:0]           arr_w_msg;
    logic                    arr_done;
    logic                    arr_clr;
    logic                    arr_out_val;
    logic                    arr_out_rdy;
    logic [BW-1:0]           arr_out_msg;
    logic [NREQ-1:0]         out_send_val;
    logic [NREQ-1:0]         out_send_rdy;
    logic [NREQ-1:0][BW-1:0] out_send_msg;
    logic                    busy;

    modport master (
        input  job_req, x_recv_val, x_recv_msg, w_recv_val, w_recv_msg,
        input  arr_x_rdy, arr_w_rdy, arr_done, arr_out_val, arr_out_msg, out_send_rdy,
        output job_gnt, x_recv_rdy, w_recv_rdy, arr_x_val, arr_x_msg, arr_w_val, arr_w_msg,
        output arr_clr, arr_out_rdy, out_send_val, out_send_msg, busy
    );

    modport slave (
        output job_req, x_recv_val, x_recv_msg, w_recv_val, w_recv_msg,
        output arr_x_rdy, arr_w_rdy, arr_done, arr_out_val, arr_out_msg, out_send_rdy,
        input  job_gnt, x_recv_rdy, w_recv_rdy, arr_x_val, arr_x_msg, arr_w_val, arr_w_msg,
        input  arr_clr, arr_out_rdy, out_send_val, out_send_msg, busy
    );

endinterface

// File: rtl/systolic_rr_arb.sv
// Round-robin requester selection: the search starts just above the last
// owner and wraps, so the previous owner has lowest priority.
module systolic_rr_arb
    import systolic_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last_owner,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx
);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req[i] && (i > int'(i_last_owner))) begin
                w_found  = 1'b1;
                o_gnt[i] = 1'b1;
                o_idx    = IW'(i);
            end
        end
        // Wrap-around pass: lowest index at or below the last owner.
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req[i]) begin
                w_found  = 1'b1;
                o_gnt[i] = 1'b1;
                o_idx    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/systolic_arbiter.sv
// Time-shares one systolic array among NREQ requesters: one job at a time,
// operands fed in, results drained back to the owner, then the array is cleared.
module systolic_arbiter
    import systolic_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int SIZE = 4,
    parameter int BW   = 32
) (
    input  logic                clk,
    input  logic                rst,
    systolic_arbiter_if.master  bus
);

    localparam int IW  = idx_w(NREQ);
    localparam int XCW = $clog2(SIZE + 1);
    localparam int OCW = $clog2(SIZE * SIZE + 1);
    localparam logic [XCW-1:0] X_FULL = XCW'(SIZE);
    localparam logic [OCW-1:0] O_FULL = OCW'(SIZE * SIZE);

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_last_owner;
    logic [XCW-1:0]  r_x_cnt;
    logic [XCW-1:0]  r_w_cnt;
    logic [OCW-1:0]  r_o_cnt;
    logic [NREQ-1:0] w_rr_gnt;
    logic [IW-1:0]   w_rr_idx;
    logic            w_x_fire;
    logic            w_w_fire;
    logic            w_o_fire;
    logic            w_o_room;
    logic [BW-1:0]   w_res_msg;

    assign w_res_msg = bus.arr_out_msg;

    systolic_rr_arb #(.NREQ(NREQ)) u_rr (
        .i_req        (bus.job_req),
        .i_last_owner (r_last_owner),
        .o_gnt        (w_rr_gnt),
        .o_idx        (w_rr_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner      <= '0;
            r_last_owner <= IW'(NREQ - 1);
            r_x_cnt      <= '0;
            r_w_cnt      <= '0;
            r_o_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE:  if (|w_rr_gnt) r_owner <= w_rr_idx;
                FEED: begin
                    if (w_x_fire) r_x_cnt <= r_x_cnt + XCW'(1);
                    if (w_w_fire) r_w_cnt <= r_w_cnt + XCW'(1);
                end
                DRAIN: if (w_o_fire) r_o_cnt <= r_o_cnt + OCW'(1);
                CLR: begin
                    r_x_cnt      <= '0;
                    r_w_cnt      <= '0;
                    r_o_cnt      <= '0;
                    r_last_owner <= r_owner;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|w_rr_gnt) w_next = FEED;
            FEED:    if ((r_x_cnt == X_FULL) && (r_w_cnt == X_FULL)) w_next = WAIT;
            WAIT:    if (bus.arr_done) w_next = DRAIN;
            DRAIN:   if (r_o_cnt == O_FULL) w_next = CLR;
            CLR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.job_gnt      = '0;
        bus.x_recv_rdy   = '0;
        bus.w_recv_rdy   = '0;
        bus.arr_x_val    = 1'b0;
        bus.arr_x_msg    = '0;
        bus.arr_w_val    = 1'b0;
        bus.arr_w_msg    = '0;
        bus.arr_clr      = 1'b0;
        bus.arr_out_rdy  = 1'b0;
        bus.out_send_val = '0;
        bus.out_send_msg = {NREQ{w_res_msg}};
        bus.busy         = (r_state != IDLE);
        w_x_fire         = 1'b0;
        w_w_fire         = 1'b0;
        w_o_fire         = 1'b0;
        w_o_room         = 1'b0;
        if (r_state != IDLE) bus.job_gnt[r_owner] = 1'b1;
        case (r_state)
            FEED: begin
                bus.arr_x_val           = bus.x_recv_val[r_owner] & (r_x_cnt < X_FULL);
                bus.x_recv_rdy[r_owner] = bus.arr_x_rdy & (r_x_cnt < X_FULL);
                bus.arr_x_msg           = bus.x_recv_msg[r_owner];
                bus.arr_w_val           = bus.w_recv_val[r_owner] & (r_w_cnt < X_FULL);
                bus.w_recv_rdy[r_owner] = bus.arr_w_rdy & (r_w_cnt < X_FULL);
                bus.arr_w_msg           = bus.w_recv_msg[r_owner];
                w_x_fire                = bus.arr_x_val & bus.arr_x_rdy;
                w_w_fire                = bus.arr_w_val & bus.arr_w_rdy;
            end
            DRAIN: begin
                // Once every result is through, stop accepting so nothing is duplicated.
                w_o_room                  = (r_o_cnt < O_FULL);
                bus.out_send_val[r_owner] = bus.arr_out_val & w_o_room;
                bus.arr_out_rdy           = bus.out_send_rdy[r_owner] & w_o_room;
                w_o_fire                  = bus.arr_out_val & bus.arr_out_rdy;
            end
            CLR:     bus.arr_clr = 1'b1;
            default: ;
        endcase
    end

endmodule
